// File: rtl/acs_compare_sequencer_if.sv
// Bundle between the ACS sequencer, its client and the shared subtractor.
// master = client/subtractor side, slave = sequencer side.
interface acs_compare_sequencer_if #(
  parameter int METRIC_W = 2
);
  logic                  start;
  logic [4*METRIC_W-1:0] cand_a;
  logic [4*METRIC_W-1:0] cand_b;
  logic [METRIC_W-1:0]   sub_a;
  logic [METRIC_W-1:0]   sub_b;
  logic                  sub_bin;
  logic                  sub_ge;
  logic                  busy;
  logic [4*METRIC_W-1:0] new_metric;
  logic [3:0]            decision;
  logic                  done;

  modport master (
    output start, cand_a, cand_b, sub_ge,
    input  sub_a, sub_b, sub_bin, busy,
    input  new_metric, decision, done
  );

  modport slave (
    input  start, cand_a, cand_b, sub_ge,
    output sub_a, sub_b, sub_bin, busy,
    output new_metric, decision, done
  );
endinterface

// File: rtl/acs_compare_sequencer.sv
// Viterbi ACS sequencer: one shared subtractor, four states compared
// serially, survivor set normalized and published on done.
module acs_compare_sequencer #(
  parameter int METRIC_W = 2
) (
  input logic                     clk,
  input logic                     rst,
  acs_compare_sequencer_if.slave  bus
);
  localparam int W = METRIC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     idx;
  logic [4*W-1:0] la;
  logic [4*W-1:0] lb;
  logic [4*W-1:0] surv;
  logic [4*W-1:0] nsurv;
  logic [4*W-1:0] norm;
  logic [3:0]     dec;
  logic [3:0]     ndec;
  logic [W-1:0]   ca;
  logic [W-1:0]   cb;
  logic [W-1:0]   sel;
  logic           allmsb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = CMP;
      CMP:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Last survivor is merged combinationally so the published set
  // is complete in the same edge that enters DONE.
  always_comb begin
    ca     = la[int'(idx)*W +: W];
    cb     = lb[int'(idx)*W +: W];
    sel    = bus.sub_ge ? cb : ca;
    nsurv  = surv;
    nsurv[int'(idx)*W +: W] = sel;
    ndec   = dec;
    ndec[idx] = bus.sub_ge;
    allmsb = 1'b1;
    for (int s = 0; s < 4; s++)
      allmsb = allmsb & nsurv[s*W+W-1];
    norm = nsurv;
    if (allmsb)
      for (int s = 0; s < 4; s++)
        norm[s*W+W-1] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      la             <= '0;
      lb             <= '0;
      surv           <= '0;
      dec            <= '0;
      bus.new_metric <= '0;
      bus.decision   <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        la  <= bus.cand_a;
        lb  <= bus.cand_b;
        idx <= '0;
      end
      if (state == CMP) begin
        surv <= nsurv;
        dec  <= ndec;
        idx  <= idx + 2'd1;
        if (idx == 2'd3) begin
          bus.new_metric <= norm;
          bus.decision   <= ndec;
        end
      end
    end
  end

  always_comb begin
    bus.sub_a   = '0;
    bus.sub_b   = '0;
    bus.sub_bin = 1'b0;
    if (state == CMP) begin
      bus.sub_a = ca;
      bus.sub_b = cb;
    end
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end
endmodule

// File: tb/tb_acs_compare_sequencer.sv
// Scoreboard bench for acs_compare_sequencer (METRIC_W=2) with a
// behavioural model of the external subtractor.
module tb_acs_compare_sequencer;
  typedef struct {
    logic [7:0] m;
    logic [3:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  acs_compare_sequencer_if #(.METRIC_W(2)) bus ();

  assign bus.sub_ge = (bus.sub_a >= bus.sub_b);

  acs_compare_sequencer #(.METRIC_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic all1;
    logic [1:0] av;
    logic [1:0] bv;
    all1 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      av = a[s*2 +: 2];
      bv = b[s*2 +: 2];
      if (bv <= av) begin
        e.m[s*2 +: 2] = bv;
        e.d[s] = 1'b1;
      end else begin
        e.m[s*2 +: 2] = av;
        e.d[s] = 1'b0;
      end
      all1 = all1 & e.m[s*2+1];
    end
    if (all1)
      for (int s = 0; s < 4; s++) e.m[s*2+1] = 1'b0;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    bus.cand_a = a;
    bus.cand_b = b;
    bus.start  = 1'b1;
    sbq.push_back(model(a, b));
    tick();
    bus.start  = 1'b0;
  endtask

  // Called in cycle T+1; returns the cycle index where done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.cand_a = 8'($urandom);
      bus.cand_b = 8'($urandom);
      tick();
    end
    nvec++;
    if ({bus.busy, bus.done, bus.new_metric, bus.decision,
         bus.sub_a, bus.sub_b, bus.sub_bin} !== 20'd0) begin
      nerr++;
      $display("FAIL reset_outputs got busy=%b done=%b nm=%h dec=%h sa=%h sb=%h bin=%b want all 0",
               bus.busy, bus.done, bus.new_metric, bus.decision,
               bus.sub_a, bus.sub_b, bus.sub_bin);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    nvec++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_start_ignored busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic;
    logic [7:0] a;
    logic [7:0] b;
    exp_t e;
    int n;
    a = {2'd3, 2'd1, 2'd2, 2'd0};
    b = {2'd0, 2'd3, 2'd2, 2'd1};
    apply(a, b);
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (bus.sub_a !== a[k*2 +: 2] || bus.sub_b !== b[k*2 +: 2] ||
          bus.sub_bin !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        nerr++;
        $display("FAIL basic_cmp%0d got sa=%h sb=%h bin=%b done=%b busy=%b want sa=%h sb=%h bin=0 done=0 busy=1",
                 k, bus.sub_a, bus.sub_b, bus.sub_bin, bus.done, bus.busy,
                 a[k*2 +: 2], b[k*2 +: 2]);
      end
      if (k < 3) tick();
    end
    tick();
    n = 5;
    nvec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      nerr++;
      $display("FAIL basic_done_t5 got done=%b busy=%b want 1 1", bus.done, bus.busy);
    end
    e = sbq.pop_front();
    nvec++;
    if (bus.new_metric !== e.m || bus.decision !== e.d) begin
      nerr++;
      $display("FAIL basic_result got nm=%h dec=%b want nm=%h dec=%b",
               bus.new_metric, bus.decision, e.m, e.d);
    end
    nvec++;
    if (bus.new_metric !== 8'b00_01_10_00 || bus.decision !== 4'b1010) begin
      nerr++;
      $display("FAIL basic_literal got nm=%h dec=%b want nm=18 dec=1010",
               bus.new_metric, bus.decision);
    end
    tick();
    nvec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || n != 5) begin
      nerr++;
      $display("FAIL basic_t6 got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_normalize;
    logic [7:0] ta[3];
    logic [7:0] tb_[3];
    logic [7:0] wm[3];
    logic [3:0] wd[3];
    exp_t e;
    int n;
    ta = '{8'hFF, 8'hFF, 8'hFD};
    tb_ = '{8'hAA, 8'hFF, 8'hAA};
    wm = '{8'h00, 8'h55, 8'hA9};
    wd = '{4'b1111, 4'b1111, 4'b1110};
    for (int i = 0; i < 3; i++) begin
      apply(ta[i], tb_[i]);
      wait_done(n);
      nvec++;
      if (n != 5) begin
        nerr++;
        $display("FAIL norm%0d_latency got %0d want 5", i, n);
      end
      e = sbq.pop_front();
      nvec++;
      if (bus.new_metric !== e.m || bus.decision !== e.d ||
          bus.new_metric !== wm[i] || bus.decision !== wd[i]) begin
        nerr++;
        $display("FAIL norm%0d_result got nm=%h dec=%b want nm=%h dec=%b",
                 i, bus.new_metric, bus.decision, wm[i], wd[i]);
      end
      tick();
    end
  endtask

  task automatic test_busy_start;
    exp_t e;
    int n;
    apply(8'h1B, 8'h6C);
    tick();
    bus.start  = 1'b1;
    bus.cand_a = 8'h00;
    bus.cand_b = 8'hFF;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    nvec++;
    if (bus.done !== 1'b1) begin
      nerr++;
      $display("FAIL busy_done_t5 got done=%b want 1", bus.done);
    end
    e = sbq.pop_front();
    nvec++;
    if (bus.new_metric !== e.m || bus.decision !== e.d) begin
      nerr++;
      $display("FAIL busy_result got nm=%h dec=%b want nm=%h dec=%b",
               bus.new_metric, bus.decision, e.m, e.d);
    end
    bus.start  = 1'b1;
    bus.cand_a = 8'hFF;
    bus.cand_b = 8'h00;
    tick();
    nvec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL busy_ignored_t6 got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    apply(8'h93, 8'h4E);
    wait_done(n);
    nvec++;
    if (n != 5) begin
      nerr++;
      $display("FAIL busy_reaccept_latency got %0d want 5", n);
    end
    e = sbq.pop_front();
    nvec++;
    if (bus.new_metric !== e.m || bus.decision !== e.d) begin
      nerr++;
      $display("FAIL busy_reaccept_result got nm=%h dec=%b want nm=%h dec=%b",
               bus.new_metric, bus.decision, e.m, e.d);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int n;
    int seen;
    apply(8'hE4, 8'h1B);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sbq.pop_front());
    nvec++;
    if ({bus.busy, bus.done, bus.new_metric, bus.decision,
         bus.sub_a, bus.sub_b, bus.sub_bin} !== 20'd0) begin
      nerr++;
      $display("FAIL midrst_outputs got busy=%b done=%b nm=%h dec=%h sa=%h sb=%h want all 0",
               bus.busy, bus.done, bus.new_metric, bus.decision, bus.sub_a, bus.sub_b);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) seen++;
      tick();
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL midrst_no_done got %0d pulses want 0", seen);
    end
    apply(8'h36, 8'hC9);
    wait_done(n);
    nvec++;
    if (n != 5) begin
      nerr++;
      $display("FAIL midrst_restart_latency got %0d want 5", n);
    end
    e = sbq.pop_front();
    nvec++;
    if (bus.new_metric !== e.m || bus.decision !== e.d) begin
      nerr++;
      $display("FAIL midrst_restart_result got nm=%h dec=%b want nm=%h dec=%b",
               bus.new_metric, bus.decision, e.m, e.d);
    end
    tick();
  endtask

  task automatic test_hold;
    exp_t e;
    int n;
    apply(8'h5A, 8'hA5);
    wait_done(n);
    e = sbq.pop_front();
    nvec++;
    if (n != 5 || bus.new_metric !== e.m || bus.decision !== e.d) begin
      nerr++;
      $display("FAIL hold_setup got n=%0d nm=%h dec=%b want n=5 nm=%h dec=%b",
               n, bus.new_metric, bus.decision, e.m, e.d);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.cand_a = 8'($urandom);
      bus.cand_b = 8'($urandom);
      nvec++;
      if (bus.new_metric !== e.m || bus.decision !== e.d ||
          bus.sub_a !== 2'd0 || bus.sub_b !== 2'd0 || bus.done !== 1'b0) begin
        nerr++;
        $display("FAIL hold%0d got nm=%h dec=%b sa=%h sb=%h done=%b want nm=%h dec=%b sa=0 sb=0 done=0",
                 i, bus.new_metric, bus.decision, bus.sub_a, bus.sub_b,
                 bus.done, e.m, e.d);
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.cand_a = '0;
    bus.cand_b = '0;
    test_reset();
    test_basic();
    test_normalize();
    test_busy_start();
    test_reset_mid();
    test_hold();
    nvec++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain got %0d left want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/acs_compare_sequencer.md
# acs_compare_sequencer

Sequencer for the Viterbi decoder's add-compare-select stage. It time-shares one external 2-bit borrow-chain subtractor across the four trellis-state comparisons of a trellis step. For each state it feeds the subtractor that state's two candidate path metrics, uses the subtractor's "A ≥ B" output to choose the survivor, normalizes the survivor set, and presents the new metrics with four decision bits.

## Interface
- `METRIC_W`, default 2: path-metric width, which matches the shared subtractor width. The number of states is fixed at 4.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request to process one trellis step. Accepted only when `busy`=0.
- `cand_a`, in, 4*METRIC_W: upper-branch candidate metrics. State s occupies bits [s*METRIC_W +: METRIC_W].
- `cand_b`, in, 4*METRIC_W: lower-branch candidate metrics, same packing as `cand_a`.
- `sub_a`, out, METRIC_W: minuend to the shared subtractor.
- `sub_b`, out, METRIC_W: subtrahend to the shared subtractor.
- `sub_bin`, out, 1: borrow-in to the subtractor, tied to 0.
- `sub_ge`, in, 1: inverted borrow-out from the subtractor. It is 1 when `sub_a` ≥ `sub_b` and is combinational from `sub_a`/`sub_b`.
- `busy`, out, 1: high from the cycle after an accepted start through the done cycle, inclusive.
- `new_metric`, out, 4*METRIC_W: survivor metrics, same packing as the candidates. Updated only in the done cycle.
- `decision`, out, 4: bit s = 1 means state s selected `cand_b`. Updated only in the done cycle.
- `done`, out, 1: one-cycle pulse when `new_metric`/`decision` update.

## Operation
- **States:**
  - IDLE → LOAD is not a separate state. A start seen in IDLE latches `cand_a`/`cand_b` into internal copies and moves to CMP with idx=0.
  - CMP with idx 0..3 drives `sub_a`/`sub_b` from the latched state-idx pair. At the cycle's end it registers `dec[idx]`=`sub_ge` and `surv[idx]` = `sub_ge` ? b : a. If idx=3 it moves to DONE; otherwise idx increments.
  - DONE moves to IDLE.
- **Selection rule:**
  - The smaller metric survives.
  - On a tie (`sub_ge`=1, equal values), `cand_b` is chosen and decision=1.
- **Normalization, applied in DONE:**
  - If the MSB is set in all four `surv` values, all four MSBs are cleared, which subtracts 2^(METRIC_W-1) from each.
  - Otherwise the values pass unchanged. Metrics never wrap.
- **Output updates:**
  - `new_metric` and `decision` load in DONE and hold until the next DONE or reset.
  - Internal `surv`/`dec` working registers are invisible until DONE.
- **Subtractor drive:** `sub_a`/`sub_b` = 0 outside CMP; `sub_bin` = 0 always.
- **Start while busy:** `start` while `busy`=1 (CMP or DONE) is ignored, with no queuing. Candidate inputs are sampled only at the accepted start.
- **Reset:**
  - `rst`=1 in any state forces IDLE, idx=0, and clears the working registers.
  - All outputs go to 0 on the next edge: `busy`, `done`, `new_metric`, `decision`, `sub_a`, `sub_b`, `sub_bin`.
  - Reset takes priority over `start` in the same cycle.
  - An aborted step never produces `done`.

## Timing
- With start accepted at edge T:
  - CMP idx 0, 1, 2 and 3 occupy cycles T+1 through T+4.
  - DONE occurs in cycle T+5, with `done`=1 and new outputs visible.
  - The block is back in IDLE at T+6.
- Latency from start to `done` is 5 cycles. Minimum start spacing is 6 cycles; the earliest re-accept is the cycle after `done`.
- `busy` is high in cycles T+1..T+5.
- The subtractor path is single-cycle combinational: `sub_a`/`sub_b` are registered, and `sub_ge` is sampled at the end of the same cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → all outputs 0; `busy`=0; a `start` held during reset is not accepted.
- **Basic step (METRIC_W=2):**
  - Stimulus: (a,b) = s0 (0,1), s1 (2,2), s2 (1,3), s3 (3,0).
  - Required: `done` at T+5 only; `new_metric` s0..s3 = 0,2,1,0; `decision`=4'b1010; no normalization.
  - Also required: `sub_a`/`sub_b` = (0,1), (2,2), (1,3), (3,0) in cycles T+1..T+4, with `sub_bin`=0.
- **Normalization:**
  - All (a,b)=(3,2): survivors are 2, so all four are normalized to 0; `decision`=4'b1111.
  - Repeat with all (3,3): `new_metric` = 1 each.
  - Repeat with s0 (1,2), others (3,2): survivors 1,2,2,2 are not normalized.
- **Start while busy:**
  - Pulse `start` with new candidates at T+2 and T+5 → ignored; the result equals the first step's values and only one `done` pulse occurs.
  - A `start` at T+6 is accepted, giving `done` at T+11.
- **Reset mid-operation:**
  - Assert `rst` at T+3 → no `done`; outputs 0 the next cycle.
  - A following start completes correctly with fresh values 5 cycles later.
- **Hold:** after a `done`, idle for 20 cycles with changing `cand_a`/`cand_b` → `new_metric`/`decision` stay unchanged and `sub_a`/`sub_b` stay 0.
